trig_pulse_gen: RTL

Programmable pulse-train generator, the output-side complement of the edge detector.
- Accepts a one-cycle `trigger`, typically a rising-edge strobe from the edge detector.
- Emits a timed level waveform on `pulse_out` after a programmable delay: `n_pulses` pulses with programmable high width and low gap.
- Sits between the feedback decision logic and the physical control lines (laser/MW gating) in the real-time feedback path.

---
 rtl/trig_pulse_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/trig_pulse_gen.sv
// Programmable pulse-train generator: after a trigger, waits delay_cyc cycles, then emits
// n_pulses pulses of width_cyc high / gap_cyc low. Optional feature macro: TRIG_PULSE_RETRIG_EN.
module trig_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [CNT_W-1:0] delay_cyc,
  input  logic [CNT_W-1:0] width_cyc,
  input  logic [CNT_W-1:0] gap_cyc,
  input  logic [NP_W-1:0]  n_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, HIGH = 2'd2, GAP = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] wid_m1, wid_m1_nxt;
  logic [CNT_W-1:0] gap_m1, gap_m1_nxt;
  logic [NP_W-1:0]  rem, rem_nxt;
  logic             accept;
  logic             pulse_nxt, busy_nxt, done_nxt, overrun_nxt;
  logic [CNT_W-1:0] wid_in_m1, gap_in_m1;
  logic [NP_W-1:0]  n_in;

  // Shadows hold (clamped value - 1) so reloads never wrap for a zero setting.
  assign wid_in_m1 = (width_cyc == '0) ? '0 : width_cyc - 1'b1;
  assign gap_in_m1 = (gap_cyc == '0) ? '0 : gap_cyc - 1'b1;
  assign n_in      = (n_pulses == '0) ? NP_W'(1) : n_pulses;

`ifdef TRIG_PULSE_RETRIG_EN
  assign accept = trigger;
`else
  assign accept = trigger && (state == IDLE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wid_m1    <= '0;
      gap_m1    <= '0;
      rem       <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wid_m1    <= wid_m1_nxt;
      gap_m1    <= gap_m1_nxt;
      rem       <= rem_nxt;
      pulse_out <= pulse_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wid_m1_nxt = wid_m1;
    gap_m1_nxt = gap_m1;
    rem_nxt    = rem;
    if (accept) begin
      wid_m1_nxt = wid_in_m1;
      gap_m1_nxt = gap_in_m1;
      rem_nxt    = n_in;
      if (delay_cyc != '0) begin
        state_nxt = DELAY;
        cnt_nxt   = delay_cyc - 1'b1;
      end else begin
        state_nxt = HIGH;
        cnt_nxt   = wid_in_m1;
      end
    end else begin
      case (state)
        DELAY: begin
          if (cnt == '0) begin
            state_nxt = HIGH;
            cnt_nxt   = wid_m1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            if (rem > NP_W'(1)) begin
              state_nxt = GAP;
              cnt_nxt   = gap_m1;
              rem_nxt   = rem - 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state_nxt = HIGH;
            cnt_nxt   = wid_m1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered images of the next state, so they line up with it exactly.
  always_comb begin
    pulse_nxt   = (state_nxt == HIGH);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state == HIGH) && (state_nxt == IDLE);
    overrun_nxt = trigger && (state != IDLE);
  end

  assign fsm_state = state;

endmodule
